// File: rtl/timing_pulse_gen_pkg.sv
// rtl/timing_pulse_gen_pkg.sv - shared FSM state, cycle geometry and strobe-phase constants
package agc_timing_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } tpg_state_e;

  localparam int N_PHASES  = 4;
  localparam int N_TPULSES = 12;

  localparam logic [1:0] PH_LAST = 2'(N_PHASES - 1);
  localparam logic [3:0] TP_LAST = 4'(N_TPULSES - 1);

  // Phase index (0 = P01) in which each active-low strobe is asserted
  localparam logic [1:0] CT_PH       = 2'd0;
  localparam logic [1:0] RT_PH_FIRST = 2'd1;
  localparam logic [1:0] RT_PH_LAST  = 2'd2;
  localparam logic [1:0] WT_PH       = 2'd2;
  localparam logic [1:0] TT_PH       = 2'd3;

endpackage

// File: rtl/timing_pulse_gen_if.sv
// rtl/timing_pulse_gen_if.sv - control inputs and phase/time-pulse/strobe bundle of the timing generator
interface timing_pulse_gen_if #(
  parameter int MCT_CNT_W = 8
) ();

  logic STRT2;
  logic MSTP;
  logic MSTRT;
  logic P01, P02, P03, P04, P04_;
  logic T01_, T02_, T03_, T04_, T05_, T06_;
  logic T07_, T08_, T09_, T10_, T11_, T12_;
  logic CT_, RT_, WT_, TT_;
  logic MT;
  logic [MCT_CNT_W-1:0] MCTCNT;
  logic RUNNING;

  modport master (
    input  STRT2, MSTP, MSTRT,
    output P01, P02, P03, P04, P04_,
    output T01_, T02_, T03_, T04_, T05_, T06_,
    output T07_, T08_, T09_, T10_, T11_, T12_,
    output CT_, RT_, WT_, TT_, MT, MCTCNT, RUNNING
  );

  modport slave (
    output STRT2, MSTP, MSTRT,
    input  P01, P02, P03, P04, P04_,
    input  T01_, T02_, T03_, T04_, T05_, T06_,
    input  T07_, T08_, T09_, T10_, T11_, T12_,
    input  CT_, RT_, WT_, TT_, MT, MCTCNT, RUNNING
  );

endinterface

// File: rtl/timing_pulse_gen_mstrt_sync_edge.sv
// rtl/timing_pulse_gen_mstrt_sync_edge.sv - two-flop synchronizer and rising-edge detector for MSTRT
module mstrt_sync_edge (
  input  logic CLOCK,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/timing_pulse_gen.sv
// rtl/timing_pulse_gen.sv - four-phase / twelve-pulse MCT timing generator with restart hold and single-MCT stepping
module timing_pulse_gen
  import agc_timing_pkg::*;
#(
  parameter int MCT_CNT_W = 8
) (
  input  logic                 CLOCK,
  input  logic                 rst,
  input  logic                 STRT2,
  input  logic                 MSTP,
  input  logic                 MSTRT,
  output logic                 P01,
  output logic                 P02,
  output logic                 P03,
  output logic                 P04,
  output logic                 P04_,
  output logic                 T01_,
  output logic                 T02_,
  output logic                 T03_,
  output logic                 T04_,
  output logic                 T05_,
  output logic                 T06_,
  output logic                 T07_,
  output logic                 T08_,
  output logic                 T09_,
  output logic                 T10_,
  output logic                 T11_,
  output logic                 T12_,
  output logic                 CT_,
  output logic                 RT_,
  output logic                 WT_,
  output logic                 TT_,
  output logic                 MT,
  output logic [MCT_CNT_W-1:0] MCTCNT,
  output logic                 RUNNING
);

  tpg_state_e           r_state, w_state_nxt;
  logic [1:0]           r_ph, w_ph_nxt;
  logic [3:0]           r_tp, w_tp_nxt;
  logic                 r_step, w_step_nxt;
  logic [MCT_CNT_W-1:0] r_mctcnt, w_mctcnt_nxt;
  logic                 w_mstrt_rise;

  logic [3:0]  r_p, w_p_nxt;
  logic [11:0] r_t_n, w_t_n_nxt;
  logic        r_ct_n, r_rt_n, r_wt_n, r_tt_n, r_mt, r_running;
  logic        w_ct_n, w_rt_n, w_wt_n, w_tt_n, w_mt, w_run;

  mstrt_sync_edge u_mstrt_sync (
    .CLOCK   (CLOCK),
    .rst     (rst),
    .i_async (MSTRT),
    .o_rise  (w_mstrt_rise)
  );

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      r_state  <= ST_HOLD;
      r_ph     <= '0;
      r_tp     <= '0;
      r_step   <= 1'b0;
      r_mctcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ph     <= w_ph_nxt;
      r_tp     <= w_tp_nxt;
      r_step   <= w_step_nxt;
      r_mctcnt <= w_mctcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ph_nxt     = r_ph;
    w_tp_nxt     = r_tp;
    w_step_nxt   = r_step;
    w_mctcnt_nxt = r_mctcnt;
    if (STRT2) begin
      w_state_nxt = ST_HOLD;
      w_ph_nxt    = '0;
      w_tp_nxt    = '0;
      w_step_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          w_ph_nxt    = '0;
          w_tp_nxt    = '0;
          w_state_nxt = MSTP ? ST_STOP : ST_RUN;
        end
        ST_RUN: begin
          if (r_ph == PH_LAST) begin
            w_ph_nxt = '0;
            if (r_tp == TP_LAST) begin
              // MCT boundary: the only point where a stop request is honoured
              w_tp_nxt     = '0;
              w_mctcnt_nxt = r_mctcnt + 1'b1;
              w_step_nxt   = 1'b0;
              if (MSTP) begin
                w_state_nxt = ST_STOP;
              end
            end else begin
              w_tp_nxt = r_tp + 4'd1;
            end
          end else begin
            w_ph_nxt = r_ph + 2'd1;
          end
        end
        ST_STOP: begin
          w_ph_nxt = '0;
          w_tp_nxt = '0;
          if (!MSTP) begin
            w_state_nxt = ST_RUN;
          end else if (w_mstrt_rise) begin
            w_step_nxt  = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_HOLD;
          w_ph_nxt    = '0;
          w_tp_nxt    = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from next-state values so they register in step with the FSM
  always_comb begin
    w_run     = (w_state_nxt == ST_RUN);
    w_p_nxt   = w_run ? (4'b0001 << w_ph_nxt) : 4'b0000;
    w_t_n_nxt = w_run ? ~(12'h001 << w_tp_nxt) : 12'hFFF;
    w_ct_n    = ~(w_run && (w_ph_nxt == CT_PH));
    w_rt_n    = ~(w_run && (w_ph_nxt >= RT_PH_FIRST) && (w_ph_nxt <= RT_PH_LAST));
    w_wt_n    = ~(w_run && (w_ph_nxt == WT_PH));
    w_tt_n    = ~(w_run && (w_ph_nxt == TT_PH));
    w_mt      = w_run && (w_ph_nxt == PH_LAST) && (w_tp_nxt == TP_LAST);
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      r_p       <= 4'b0000;
      r_t_n     <= 12'hFFF;
      r_ct_n    <= 1'b1;
      r_rt_n    <= 1'b1;
      r_wt_n    <= 1'b1;
      r_tt_n    <= 1'b1;
      r_mt      <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_p       <= w_p_nxt;
      r_t_n     <= w_t_n_nxt;
      r_ct_n    <= w_ct_n;
      r_rt_n    <= w_rt_n;
      r_wt_n    <= w_wt_n;
      r_tt_n    <= w_tt_n;
      r_mt      <= w_mt;
      r_running <= w_run;
    end
  end

  assign P01     = r_p[0];
  assign P02     = r_p[1];
  assign P03     = r_p[2];
  assign P04     = r_p[3];
  assign P04_    = ~r_p[3];
  assign T01_    = r_t_n[0];
  assign T02_    = r_t_n[1];
  assign T03_    = r_t_n[2];
  assign T04_    = r_t_n[3];
  assign T05_    = r_t_n[4];
  assign T06_    = r_t_n[5];
  assign T07_    = r_t_n[6];
  assign T08_    = r_t_n[7];
  assign T09_    = r_t_n[8];
  assign T10_    = r_t_n[9];
  assign T11_    = r_t_n[10];
  assign T12_    = r_t_n[11];
  assign CT_     = r_ct_n;
  assign RT_     = r_rt_n;
  assign WT_     = r_wt_n;
  assign TT_     = r_tt_n;
  assign MT      = r_mt;
  assign MCTCNT  = r_mctcnt;
  assign RUNNING = r_running;

endmodule

// File: doc/timing_pulse_gen.md
# timing_pulse_gen

Master timing generator for the control section. It divides CLOCK into four phases per time pulse and twelve time pulses per memory cycle time (MCT). It produces the phase, time-pulse and read/write/clear/test strobes consumed directly by the service-gate logic downstream (P04_, T10_, CT_, RT_, WT_, TT_). It also handles restart hold (STRT2) and manual stop/single-MCT stepping (MSTP/MSTRT).

## Interface
Parameters:
- MCT_CNT_W, 8, width of the free-running MCT counter output.

Ports:
- CLOCK  in  1  master clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- STRT2  in  1  restart hold; active-high, level-sensitive.
- MSTP  in  1  monitor stop request; active-high, level.
- MSTRT  in  1  monitor start; asynchronous to CLOCK, acted on at its rising edge.
- P01, P02, P03, P04  out  1 each  phase pulses, active-high, one-hot while running.
- P04_  out  1  inverse of P04.
- T01_ … T12_  out  1 each  time pulses, active-low, one-hot while running.
- CT_  out  1  clear strobe, active-low.
- RT_  out  1  read strobe, active-low.
- WT_  out  1  write strobe, active-low.
- TT_  out  1  test strobe, active-low.
- MT  out  1  end-of-MCT strobe, active-high.
- MCTCNT  out  MCT_CNT_W  completed-MCT count, wraps.
- RUNNING  out  1  high in RUN state.

## Operation
- State registers:
  - phase counter ph (0..3 ↔ P01..P04);
  - time counter tp (0..11 ↔ T01..T12);
  - FSM state ∈ {HOLD, RUN, STOP};
  - MCTCNT;
  - step flag.
- All outputs are registered, decoded from next-state values, so no combinational glitches reach downstream gates.
- Strobes in RUN, per time pulse:
  - CT_ low during P01.
  - RT_ low during P02 and P03.
  - WT_ low during P03.
  - TT_ low during P04.
- MT is high only at T12/P04.
- Idle output set, used in HOLD and STOP:
  - All Txx_ = 1.
  - P01..P04 = 0, P04_ = 1.
  - CT_ = RT_ = WT_ = TT_ = 1.
  - MT = 0, RUNNING = 0.
- FSM:
  - HOLD: entered on rst or STRT2=1, from any state and with any ph/tp. Counters are cleared, so ph=0, tp=0 on exit. Exits to RUN when STRT2=0, or to STOP when STRT2=0 and MSTP=1.
  - RUN: ph increments every cycle. On ph=3, ph wraps and tp increments. On tp=11 and ph=3, tp wraps, MCTCNT increments (mod 2^MCT_CNT_W) and MT fires. At that MCT boundary:
    - MSTP=1 → STOP, unless step flag is set, in which case the flag is cleared and the FSM goes to STOP anyway.
    - MSTP=0 → continue RUN.
    - MSTP asserted mid-MCT never truncates the MCT.
  - STOP: counters are held at 0. A synchronized MSTRT rising edge sets the step flag and enters RUN for exactly one full MCT, then returns to STOP while MSTP=1. If MSTP=0 in STOP, resume RUN next cycle.
- MSTRT:
  - Passes through a 2-flop synchronizer plus edge detect.
  - Edges in RUN or HOLD are discarded, not queued.
- Priority: rst > STRT2 > MSTP/MSTRT.
- rst also clears MCTCNT. STRT2 does not clear MCTCNT.

## Timing
- Reset values: idle output set; MCTCNT = 0; state HOLD; step flag 0; synchronizer flops 0.
- First active cycle: one cycle after the first edge where STRT2=0 (and rst=0), outputs show T01_=0 and P01=1.
- Cycle counts: one time pulse = 4 CLOCK cycles; one MCT = 48 cycles.
- MT and MCTCNT:
  - MT is high for exactly 1 cycle per MCT.
  - The MCTCNT increment is visible the cycle after MT.
- Stop on MSTP: with MSTP=1 before T12/P04, outputs go idle the cycle after MT.
- Single step: MSTRT edge to T01/P01 latency is 3 cycles (2 synchronizer + 1 register).
- Mid-operation STRT2 or rst: outputs go idle on the next cycle, with no completion of the current MCT.

## Structure
- Package agc_timing_pkg holds:
  - the FSM state enum;
  - constants N_PHASES=4 and N_TPULSES=12;
  - strobe-phase constants (CT_PH, RT_PH_FIRST, RT_PH_LAST, WT_PH, TT_PH).
- Sub-module mstrt_sync_edge: 2-flop synchronizer plus rising-edge detector on MSTRT, reset by rst.

## Test plan
- rst=1 for 2 cycles, STRT2=1 for 10 more, then STRT2=0 → idle outputs throughout hold; T01_=0, P01=1, CT_=0 one cycle after release; MT pulses every 48 cycles; MCTCNT=3 after 3 MCTs.
- Run 2 MCTs and check the strobe pattern each time pulse: CT_ low at P01, RT_ low at P02–P03, WT_ low at P03 only, TT_ low at P04; T10_ low for cycles 36–39 of the MCT.
- Assert MSTP at T05 → MCT completes through T12/P04 with MT=1, then outputs go idle and RUNNING=0; counters stay at 0.
- In STOP, pulse MSTRT high for 5 cycles → exactly one 48-cycle MCT starting 3 cycles after the edge, MCTCNT+1, back to STOP; a second MSTRT edge issued during that MCT is ignored.
- Assert STRT2 at T07/P02 → idle next cycle; on release, restart at T01/P01; MCTCNT unchanged.
- Set MCT_CNT_W=2, run 5 MCTs → MCTCNT sequence 1,2,3,0,1.
